mem_wb_stage_buf: RTL and testbench

//  Parametrised MEM->WB pipeline boundary for the multi-issue core. Carries LANES parallel lanes of

---
 rtl/mem_wb_stage_buf_if.sv | 46 ++++
 rtl/mem_wb_stage_buf.sv | 129 ++++++++++++
 tb/tb_mem_wb_stage_buf.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_buf_if.sv
// MEM->WB boundary bundle: the MEM-side beat with its valid/ready pair, and the WB-side
// writeback, debug-commit and retire-count signals produced by the stage buffer.
interface mem_wb_stage_buf_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 64
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ADDR_W-1:0] in_wd;
  logic [LANES-1:0]        in_wreg;
  logic [LANES*DATA_W-1:0] in_wdata;
  logic [LANES*PC_W-1:0]   in_pc;
  logic [LANES*PC_W-1:0]   in_instr;
  logic [LANES-1:0]        in_inst_valid;
  logic [LANES-1:0]        in_llbit_we;
  logic [LANES-1:0]        in_llbit_value;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [LANES-1:0]        wb_llbit_we;
  logic [LANES-1:0]        wb_llbit_value;
  logic [LANES*PC_W-1:0]   debug_commit_pc;
  logic [LANES*PC_W-1:0]   debug_commit_instr;
  logic [LANES-1:0]        debug_commit_valid;
  logic [CNT_W-1:0]        commit_count;

  modport master (
    output in_valid, in_wd, in_wreg, in_wdata, in_pc, in_instr, in_inst_valid,
           in_llbit_we, in_llbit_value, out_ready,
    input  in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_llbit_we, wb_llbit_value,
           debug_commit_pc, debug_commit_instr, debug_commit_valid, commit_count
  );

  modport slave (
    input  in_valid, in_wd, in_wreg, in_wdata, in_pc, in_instr, in_inst_valid,
           in_llbit_we, in_llbit_value, out_ready,
    output in_ready, out_valid, wb_wd, wb_wreg, wb_wdata, wb_llbit_we, wb_llbit_value,
           debug_commit_pc, debug_commit_instr, debug_commit_valid, commit_count
  );
endinterface

// File: rtl/mem_wb_stage_buf.sv
// MEM->WB pipeline boundary: 2-entry skid buffer (main + skid) so in_ready depends only on
// registered state, with flush, gated writeback enables and a retired-instruction counter.
module mem_wb_stage_buf #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_stage_buf_if.slave bus
);

  typedef struct packed {
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
    logic [LANES*PC_W-1:0]   pc;
    logic [LANES*PC_W-1:0]   instr;
    logic [LANES-1:0]        inst_valid;
    logic [LANES-1:0]        llbit_we;
    logic [LANES-1:0]        llbit_value;
  } beat_t;

  // Encoding is {main_v, skid_v}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  state_e           state_p0, state_nx;
  beat_t            in_beat;
  beat_t            main_p0, skid_p0;
  logic             main_v, skid_v;
  logic             accept, pop;
  logic             ld_main_in, ld_main_skid, ld_skid;
  logic [LANES-1:0] commit_vld;
  logic [CNT_W-1:0] commit_count_p0;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  assign in_beat = {bus.in_wd, bus.in_wreg, bus.in_wdata, bus.in_pc, bus.in_instr,
                    bus.in_inst_valid, bus.in_llbit_we, bus.in_llbit_value};

  assign main_v = state_p0[1];
  assign skid_v = state_p0[0];
  assign accept = bus.in_valid & ~skid_v;
  assign pop    = main_v & bus.out_ready;

  always_comb begin
    state_nx     = state_p0;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_p0)
      EMPTY: if (accept) begin
        ld_main_in = 1'b1;
        state_nx   = ONE;
      end
      ONE: begin
        if (accept && pop) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid  = 1'b1;
          state_nx = TWO;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      TWO: if (pop) begin
        ld_main_skid = 1'b1;
        state_nx     = ONE;
      end
      default: state_nx = EMPTY;
    endcase
    // Flush wins over everything; the arriving beat is not captured.
    if (flush) begin
      state_nx     = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // ---- stage p0: control state, payload holding registers, retire counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p0 <= EMPTY;
    else     state_p0 <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      if (ld_main_in)        main_p0 <= in_beat;
      else if (ld_main_skid) main_p0 <= skid_p0;
      if (ld_skid)           skid_p0 <= in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) commit_count_p0 <= '0;
    else     commit_count_p0 <= commit_count_p0 + popcount(commit_vld);
  end

  // Payload is left in place after a pop; every enable is gated so stale data never writes.
  assign commit_vld             = main_p0.inst_valid & {LANES{pop}};
  assign bus.in_ready           = ~skid_v;
  assign bus.out_valid          = main_v;
  assign bus.wb_wd              = main_p0.wd;
  assign bus.wb_wreg            = main_p0.wreg & {LANES{main_v}};
  assign bus.wb_wdata           = main_p0.wdata;
  assign bus.wb_llbit_we        = main_p0.llbit_we & {LANES{main_v}};
  assign bus.wb_llbit_value     = main_p0.llbit_value;
  assign bus.debug_commit_pc    = main_p0.pc;
  assign bus.debug_commit_instr = main_p0.instr;
  assign bus.debug_commit_valid = commit_vld;
  assign bus.commit_count       = commit_count_p0;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Bench for mem_wb_stage_buf: directed scenarios plus random traffic against a queue-based model.
module tb_mem_wb_stage_buf;

  typedef struct packed {
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [63:0] instr;
    logic [1:0]  iv;
    logic [1:0]  llwe;
    logic [1:0]  llv;
  } beat_t;

  logic clk;
  logic rst;
  logic flush;

  mem_wb_stage_buf_if #(.LANES(2), .DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(64)) bus ();
  mem_wb_stage_buf_if #(.LANES(2), .DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(4))  bus4 ();

  mem_wb_stage_buf #(.LANES(2), .DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  mem_wb_stage_buf #(.LANES(2), .DATA_W(32), .ADDR_W(5), .PC_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus4)
  );

  // The narrow-counter instance sees exactly the same traffic.
  assign bus4.in_valid       = bus.in_valid;
  assign bus4.in_wd          = bus.in_wd;
  assign bus4.in_wreg        = bus.in_wreg;
  assign bus4.in_wdata       = bus.in_wdata;
  assign bus4.in_pc          = bus.in_pc;
  assign bus4.in_instr       = bus.in_instr;
  assign bus4.in_inst_valid  = bus.in_inst_valid;
  assign bus4.in_llbit_we    = bus.in_llbit_we;
  assign bus4.in_llbit_value = bus.in_llbit_value;
  assign bus4.out_ready      = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  beat_t       q[$];
  beat_t       cur;
  logic [63:0] cnt;
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.wd    = 10'($urandom);
    b.wreg  = 2'($urandom);
    b.wdata = {$urandom, $urandom};
    b.pc    = {$urandom, $urandom};
    b.instr = {$urandom, $urandom};
    b.iv    = 2'($urandom);
    b.llwe  = 2'($urandom);
    b.llv   = 2'($urandom);
    return b;
  endfunction

  task automatic set_in(input beat_t b, input bit v);
    cur                = b;
    bus.in_valid       = v;
    bus.in_wd          = b.wd;
    bus.in_wreg        = b.wreg;
    bus.in_wdata       = b.wdata;
    bus.in_pc          = b.pc;
    bus.in_instr       = b.instr;
    bus.in_inst_valid  = b.iv;
    bus.in_llbit_we    = b.llwe;
    bus.in_llbit_value = b.llv;
  endtask

  task automatic check_outputs();
    bit ov;
    ov = (q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, ov);
    chk("commit_count", bus.commit_count, cnt);
    chk("commit_count4", bus4.commit_count, cnt & 64'hF);
    if (ov) begin
      chk("wb_wd", bus.wb_wd, q[0].wd);
      chk("wb_wdata", bus.wb_wdata, q[0].wdata);
      chk("wb_wreg", bus.wb_wreg, q[0].wreg);
      chk("wb_llbit_we", bus.wb_llbit_we, q[0].llwe);
      chk("wb_llbit_value", bus.wb_llbit_value, q[0].llv);
      chk("dbg_pc", bus.debug_commit_pc, q[0].pc);
      chk("dbg_instr", bus.debug_commit_instr, q[0].instr);
      chk("dbg_valid", bus.debug_commit_valid, bus.out_ready ? q[0].iv : 2'b00);
    end else begin
      chk("wb_wreg_idle", bus.wb_wreg, 0);
      chk("wb_llbit_we_idle", bus.wb_llbit_we, 0);
      chk("dbg_valid_idle", bus.debug_commit_valid, 0);
    end
  endtask

  // One clock: check at negedge, then advance the model across the posedge.
  task automatic cycle();
    bit acc, pop;
    @(negedge clk);
    check_outputs();
    acc = bus.in_valid && (q.size() < 2);
    pop = (q.size() > 0) && bus.out_ready;
    @(posedge clk);
    #1;
    if (pop) cnt = cnt + 64'($countones(q[0].iv));
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    last_acc = acc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    cnt = '0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.commit_count, 0);
    chk("rst_wdata", bus.wb_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t       b;
    logic [63:0] c0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    cnt           = '0;
    last_acc      = 1'b0;
    set_in('0, 1'b0);
    do_reset();

    // Single beat, immediate consume
    b         = '0;
    b.wd      = 10'd3;
    b.wreg    = 2'b01;
    b.wdata   = 64'h0000_0000_DEAD_BEEF;
    b.iv      = 2'b11;
    bus.out_ready = 1'b1;
    set_in(b, 1'b1);
    cycle();
    set_in('0, 1'b0);
    chk("t1_latency", bus.out_valid, 1);
    chk("t1_wdata_lane0", bus.wb_wdata[31:0], 32'hDEAD_BEEF);
    chk("t1_dbg_valid", bus.debug_commit_valid, 2'b11);
    cycle();
    chk("t1_count", bus.commit_count, 2);

    // Back-pressure: A, B fill the buffer, C waits
    bus.out_ready = 1'b0;
    set_in(rand_beat(), 1'b1); cycle();
    set_in(rand_beat(), 1'b1); cycle();
    chk("t2_in_ready_low", bus.in_ready, 0);
    set_in(rand_beat(), 1'b1);
    cycle(); cycle();
    bus.out_ready = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 10 && !last_acc; k++) cycle();
    chk("t2_c_accepted", last_acc, 1);
    set_in('0, 1'b0);
    for (int k = 0; k < 4; k++) cycle();

    // Flush while full
    bus.out_ready = 1'b0;
    set_in(rand_beat(), 1'b1); cycle();
    set_in(rand_beat(), 1'b1); cycle();
    c0 = cnt;
    flush = 1'b1;
    set_in(rand_beat(), 1'b1);
    cycle();
    flush = 1'b0;
    set_in('0, 1'b0);
    chk("t3_out_valid", bus.out_valid, 0);
    chk("t3_in_ready", bus.in_ready, 1);
    chk("t3_wb_wreg", bus.wb_wreg, 0);
    chk("t3_count", bus.commit_count, c0);
    cycle();

    // inst_valid does not gate wb_wreg
    c0 = cnt;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b      = rand_beat();
      b.iv   = 2'b01;
      b.wreg = 2'b11;
      set_in(b, 1'b1);
      cycle();
      chk("t4_wb_wreg", bus.wb_wreg, 2'b11);
    end
    set_in('0, 1'b0);
    cycle(); cycle();
    chk("t4_count", bus.commit_count, c0 + 3);

    // Narrow counter wrap
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      b    = rand_beat();
      b.iv = 2'b11;
      set_in(b, 1'b1);
      cycle();
    end
    set_in('0, 1'b0);
    cycle(); cycle();
    chk("t5_count4_14", bus4.commit_count, 14);
    b    = rand_beat();
    b.iv = 2'b11;
    set_in(b, 1'b1);
    cycle();
    set_in('0, 1'b0);
    cycle(); cycle();
    chk("t5_count4_wrap", bus4.commit_count, 0);
    chk("t5_count64", bus.commit_count, 16);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      set_in(rand_beat(), ($urandom_range(0, 9) < 6));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 99) < 3);
      cycle();
    end
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(rand_beat(), 1'b1); cycle();
    bus.out_ready = 1'b0;
    set_in(rand_beat(), 1'b1); cycle();
    set_in(rand_beat(), 1'b1); cycle();
    set_in('0, 1'b0);

    // Async reset mid-cycle while holding two beats
    chk("t6_full_before", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    cnt = '0;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_count", bus.commit_count, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_in(rand_beat(), 1'b1); cycle();
    set_in('0, 1'b0);
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
